// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder and its write buffer.
package dmem_responder_pkg;

  localparam int unsigned WBUF_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // One buffered store: word address plus data.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Pipeline MEM-stage and backing-RAM signal bundle for dmem_responder.
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH = WBUF_DEPTH_DEF
) ();

  localparam int unsigned CW = $clog2(WBUF_DEPTH) + 1;

  // Pipeline side
  logic          mem_ren;
  logic          mem_wen;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_dout;
  logic [31:0]   mem_din;
  logic          mem_stall;

  // Backing RAM side
  logic          ram_req;
  logic          ram_we;
  logic [31:0]   ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic          ram_ack;

  logic [CW-1:0] wbuf_count;

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata, ram_ack,
    output mem_din, mem_stall, ram_req, ram_we, ram_addr, ram_wdata, wbuf_count
  );

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata, ram_ack,
    input  mem_din, mem_stall, ram_req, ram_we, ram_addr, ram_wdata, wbuf_count
  );

endinterface

// File: rtl/dmem_responder_wbuf_fifo.sv
// Write buffer: circular FIFO of pending stores with a youngest-match lookup
// used to forward buffered data to reads.
module wbuf_fifo
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = WBUF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  wbuf_entry_t            push_entry_i,
  input  logic                   pop_i,
  output wbuf_entry_t            head_entry_o,
  output logic [$clog2(DEPTH):0] count_o,
  input  logic [29:0]            lookup_waddr_i,
  output logic                   hit_o,
  output logic [31:0]            hit_data_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wbuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] idx;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + PW'(1);
    if (pop_i)  head_d = head_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage, written only at the tail; stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (mem_q[idx].waddr == lookup_waddr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[idx].data;
      end
    end
  end

  assign head_entry_o = mem_q[head_q];
  assign count_o      = count_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: buffers pipeline stores, forwards buffered data to
// reads, and sequences drains and read-miss fetches on the backing RAM.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned CW = $clog2(WBUF_DEPTH) + 1;

  state_t        state_q, state_d;
  logic          ram_req_q, ram_req_d;
  logic          ram_we_q, ram_we_d;
  logic [31:0]   ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [CW-1:0] count;
  wbuf_entry_t   head_entry;
  wbuf_entry_t   push_entry;
  logic          push, pop, hit, full, write_req, read_miss;
  logic [31:0]   hit_data;
  logic          stall_c;
  logic [31:0]   din_c;
  logic          unused_addr_lsbs;

  // Byte offset is irrelevant for word-only accesses.
  assign unused_addr_lsbs = ^bus.mem_addr[1:0];

  assign full       = (count == CW'(WBUF_DEPTH));
  assign write_req  = bus.mem_wen & ~bus.mem_ren;
  assign push       = write_req & ~full;
  assign read_miss  = bus.mem_ren & ~hit;
  assign push_entry = '{waddr: bus.mem_addr[31:2], data: bus.mem_dout};

  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push),
    .push_entry_i   (push_entry),
    .pop_i          (pop),
    .head_entry_o   (head_entry),
    .count_o        (count),
    .lookup_waddr_i (bus.mem_addr[31:2]),
    .hit_o          (hit),
    .hit_data_o     (hit_data)
  );

  // Next state and next RAM request; a read miss beats a new drain but an
  // in-flight drain always runs to its ack.
  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_miss) begin
          state_d     = READ;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b0;
          ram_addr_d  = {bus.mem_addr[31:2], 2'b00};
          ram_wdata_d = '0;
        end else if (count != '0) begin
          state_d     = DRAIN;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = {head_entry.waddr, 2'b00};
          ram_wdata_d = head_entry.data;
        end
      end
      DRAIN: begin
        if (bus.ram_ack) begin
          pop       = 1'b1;
          state_d   = IDLE;
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
        end
      end
      READ: begin
        if (bus.ram_ack) begin
          rdata_d   = bus.ram_rdata;
          state_d   = RESP;
          ram_req_d = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        ram_req_d = 1'b0;
        ram_we_d  = 1'b0;
      end
    endcase
  end

  // FSM state, registered RAM request and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Pipeline-facing stall and read data; reads take precedence over writes.
  always_comb begin
    stall_c = 1'b0;
    din_c   = '0;
    if (bus.mem_ren) begin
      if (state_q == RESP) begin
        din_c = rdata_q;
      end else begin
        stall_c = ~hit;
        din_c   = hit ? hit_data : '0;
      end
    end else if (bus.mem_wen) begin
      stall_c = full;
    end
  end

  assign bus.mem_stall  = stall_c & ~rst;
  assign bus.mem_din    = rst ? '0 : din_c;
  assign bus.ram_req    = ram_req_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.wbuf_count = count;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a flat memory model predicts read data,
// a store queue predicts RAM write order, and a RAM responder with
// programmable ack latency plays the backing memory.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 4;
  localparam int          NEVER = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.WBUF_DEPTH(DEPTH)) bus ();

  dmem_responder #(.WBUF_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_mem   [logic [29:0]];
  logic [31:0] model_mem [logic [29:0]];
  logic [31:0] sb_q      [$];
  logic [61:0] drain_q   [$];
  logic [30:0] ram_log   [$];

  int ack_delay     = NEVER;
  int wait_cnt      = 0;
  bit ack_pulse     = 1'b0;
  bit late_ack      = 1'b0;
  bit rand_delay    = 1'b0;
  int nwrites       = 0;
  int rd_req_cycles = 0;

  logic        pend;
  logic [31:0] pa, pd;
  logic        pw;

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [29:0] w);
    return ram_mem.exists(w) ? ram_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] model_rd(input logic [29:0] w);
    return model_mem.exists(w) ? model_mem[w] : init_word(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic set_ack(input int d);
    ack_delay = d;
    wait_cnt  = 0;
  endtask

  // Present one request and hold it until the DUT stops stalling.
  task automatic do_op(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                       output int stalls);
    bit ok;
    bus.mem_wen  = is_wr;
    bus.mem_ren  = !is_wr;
    bus.mem_addr = a;
    bus.mem_dout = d;
    if (!is_wr) sb_q.push_back(model_rd(a[31:2]));
    stalls = 0;
    ok     = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.mem_stall) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL op_timeout addr=0x%08h mem_stall stuck at 1, required 0", a);
      if (!is_wr) void'(sb_q.pop_back());
    end else begin
      @(posedge clk);
      #1;
      if (is_wr) begin
        model_mem[a[31:2]] = d;
        drain_q.push_back({a[31:2], d});
      end
    end
    bus.mem_wen = 1'b0;
    bus.mem_ren = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    checks++;
    while ((bus.wbuf_count != '0 || bus.ram_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      errors++;
      $display("FAIL wait_empty wbuf_count=%0d ram_req=%0d, required 0 and 0",
               bus.wbuf_count, bus.ram_req);
    end
    @(posedge clk);
    #1;
  endtask

  // Backing RAM: acks after ack_delay waiting cycles, checks write order and
  // request stability while waiting.
  initial begin
    logic [61:0] exp_w;
    pend = 1'b0; pa = '0; pd = '0; pw = 1'b0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(negedge clk);
      bus.ram_ack = 1'b0;
      if (pend && bus.ram_req && !rst) begin
        chk("ram_addr_stable", bus.ram_addr, pa);
        chk("ram_wdata_stable", bus.ram_wdata, pd);
        chk("ram_we_stable", 32'(bus.ram_we), 32'(pw));
      end
      pend = 1'b0;
      if (late_ack) begin
        bus.ram_ack = 1'b1;
      end else if (bus.ram_req && !rst) begin
        if (!bus.ram_we) rd_req_cycles++;
        if (ack_pulse || (ack_delay != NEVER && wait_cnt >= ack_delay)) begin
          bus.ram_ack = 1'b1;
          ack_pulse   = 1'b0;
          wait_cnt    = 0;
          ram_log.push_back({bus.ram_we, bus.ram_addr[31:2]});
          if (bus.ram_we) begin
            nwrites++;
            checks++;
            if (drain_q.size() == 0) begin
              errors++;
              $display("FAIL ram_write_unexpected addr=0x%08h data=0x%08h, required no write",
                       bus.ram_addr, bus.ram_wdata);
            end else begin
              exp_w = drain_q.pop_front();
              if ({bus.ram_addr[31:2], bus.ram_wdata} !== exp_w) begin
                errors++;
                $display("FAIL ram_write_order actual=0x%016h expected=0x%016h",
                         {bus.ram_addr[31:2], bus.ram_wdata}, exp_w);
              end
            end
            ram_mem[bus.ram_addr[31:2]] = bus.ram_wdata;
          end else begin
            bus.ram_rdata = ram_rd(bus.ram_addr[31:2]);
          end
          if (rand_delay) ack_delay = int'($urandom_range(0, 3));
        end else begin
          wait_cnt++;
          pend = 1'b1;
          pa   = bus.ram_addr;
          pd   = bus.ram_wdata;
          pw   = bus.ram_we;
        end
      end
    end
  end

  // Read-data monitor: pops the scoreboard whenever a read completes.
  initial begin
    logic [31:0] exp_d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_ren && !bus.mem_stall) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected mem_din=0x%08h, required no completion", bus.mem_din);
          end else begin
            exp_d = sb_q.pop_front();
            if (bus.mem_din !== exp_d) begin
              errors++;
              $display("FAIL rd_data addr=0x%08h actual=0x%08h expected=0x%08h",
                       bus.mem_addr, bus.mem_din, exp_d);
            end
          end
        end else if (!bus.mem_ren) begin
          chk("din_idle_zero", bus.mem_din, 32'h0);
        end
      end
    end
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    int          st, r0, nw0;
    int unsigned r;
    logic [31:0] a;
    logic [30:0] exp39 [4];

    bus.mem_ren = 1'b0; bus.mem_wen = 1'b0; bus.mem_addr = '0; bus.mem_dout = '0;

    // Reset state with a read request present
    #1 rst = 1'b1;
    bus.mem_ren  = 1'b1;
    bus.mem_addr = 32'h44;
    #2;
    chk("rst_ram_req",    32'(bus.ram_req), 32'h0);
    chk("rst_ram_we",     32'(bus.ram_we), 32'h0);
    chk("rst_ram_addr",   bus.ram_addr, 32'h0);
    chk("rst_ram_wdata",  bus.ram_wdata, 32'h0);
    chk("rst_mem_stall",  32'(bus.mem_stall), 32'h0);
    chk("rst_wbuf_count", 32'(bus.wbuf_count), 32'h0);
    chk("rst_mem_din",    bus.mem_din, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    bus.mem_ren = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_wbuf_count", 32'(bus.wbuf_count), 32'h0);
    chk("idle_ram_req", 32'(bus.ram_req), 32'h0);

    // Write then read same word: forwarded, no RAM read
    set_ack(NEVER);
    do_op(1'b1, 32'h100, 32'hDEADBEEF, st);
    r0 = rd_req_cycles;
    do_op(1'b0, 32'h100, 32'h0, st);
    chk("t35_hit_stalls", 32'(st), 32'h0);
    chk("t35_no_ram_read", 32'(rd_req_cycles - r0), 32'h0);
    set_ack(0);
    wait_empty();

    // Youngest match among two buffered writes to one word
    set_ack(NEVER);
    do_op(1'b1, 32'h20, 32'h1, st);
    do_op(1'b1, 32'h22, 32'h2, st);
    chk("t36_count", 32'(bus.wbuf_count), 32'h2);
    do_op(1'b0, 32'h20, 32'h0, st);
    chk("t36_hit_stalls", 32'(st), 32'h0);
    set_ack(0);
    wait_empty();

    // Full buffer: fifth write stalls until one drain is acked
    set_ack(NEVER);
    for (int i = 0; i < 4; i++) do_op(1'b1, 32'h500 + 32'(i * 4), 32'(100 + i), st);
    chk("t37_count_full", 32'(bus.wbuf_count), 32'h4);
    bus.mem_wen  = 1'b1;
    bus.mem_addr = 32'h510;
    bus.mem_dout = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t37_full_stall", 32'(bus.mem_stall), 32'h1);
      chk("t37_count_peak", 32'(bus.wbuf_count), 32'h4);
    end
    #1 ack_pulse = 1'b1;
    do_op(1'b1, 32'h510, 32'h55, st);
    chk("t37_stalls_after_ack", 32'(st), 32'h1);
    chk("t37_count_after_accept", 32'(bus.wbuf_count), 32'h4);
    set_ack(0);
    wait_empty();

    // Read miss with immediate ack
    ram_mem[30'h10]   = 32'h12345678;
    model_mem[30'h10] = 32'h12345678;
    do_op(1'b0, 32'h40, 32'h0, st);
    chk("t38_miss_stalls", 32'(st), 32'h2);

    // Miss arriving during a slow drain
    ram_log.delete();
    set_ack(NEVER);
    do_op(1'b1, 32'h200, 32'hA0, st);
    do_op(1'b1, 32'h204, 32'hA1, st);
    do_op(1'b1, 32'h208, 32'hA2, st);
    set_ack(3);
    do_op(1'b0, 32'h300, 32'h0, st);
    wait_empty();
    exp39[0] = {1'b1, 30'h80};
    exp39[1] = {1'b0, 30'hC0};
    exp39[2] = {1'b1, 30'h81};
    exp39[3] = {1'b1, 30'h82};
    chk("t39_log_size", 32'(ram_log.size()), 32'h4);
    for (int i = 0; i < 4; i++)
      chk("t39_ram_order", (ram_log.size() > i) ? 32'(ram_log[i]) : 32'hFFFF_FFFF, 32'(exp39[i]));

    // Reset during an in-flight drain with three entries buffered
    set_ack(NEVER);
    do_op(1'b1, 32'h600, 32'hB0, st);
    do_op(1'b1, 32'h604, 32'hB1, st);
    do_op(1'b1, 32'h608, 32'hB2, st);
    chk("t40_pre_ram_req", 32'(bus.ram_req), 32'h1);
    chk("t40_pre_count", 32'(bus.wbuf_count), 32'h3);
    rst = 1'b1;
    #1;
    chk("t40_ram_req", 32'(bus.ram_req), 32'h0);
    chk("t40_ram_we", 32'(bus.ram_we), 32'h0);
    chk("t40_ram_addr", bus.ram_addr, 32'h0);
    chk("t40_count", 32'(bus.wbuf_count), 32'h0);
    drain_q.delete();
    model_mem = ram_mem;
    nw0 = nwrites;
    @(posedge clk); #1;
    rst = 1'b0;
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1 late_ack = 1'b0;
    set_ack(0);
    repeat (10) @(negedge clk);
    chk("t40_no_ram_write", 32'(nwrites - nw0), 32'h0);
    chk("t40_post_ram_req", 32'(bus.ram_req), 32'h0);
    chk("t40_post_count", 32'(bus.wbuf_count), 32'h0);
    @(posedge clk); #1;
    do_op(1'b0, 32'h604, 32'h0, st);

    // Randomized traffic over a small address window
    rand_delay = 1'b1;
    set_ack(1);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      a = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      if (r < 4)      do_op(1'b1, a, $urandom, st);
      else if (r < 8) do_op(1'b0, a, 32'h0, st);
      else begin
        @(posedge clk);
        #1;
      end
    end
    rand_delay = 1'b0;
    set_ack(0);
    wait_empty();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    chk("drain_q_empty", 32'(drain_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
